// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with per-channel enable, period tick
// and a valid/ready config port whose updates take effect only at period boundaries.
module clk_div_multi #(
    parameter int                CHANNELS    = 4,
    parameter int                WIDTH       = 28,
    parameter int                SEL_W       = 2,
    parameter logic [WIDTH-1:0]  DEFAULT_DIV = 28'd143266
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [SEL_W-1:0]     cfg_chan,
    input  logic [WIDTH-1:0]     cfg_div,
    input  logic [WIDTH-1:0]     cfg_high,
    output logic [CHANNELS-1:0]  clock_out,
    output logic [CHANNELS-1:0]  tick
);

    localparam logic [WIDTH-1:0] DEFAULT_HIGH = DEFAULT_DIV >> 1;
    localparam int               SEL_SPAN     = 1 << SEL_W;

    logic [CHANNELS-1:0] pend_flags;
    logic [SEL_SPAN-1:0] pend_map;
    logic [WIDTH-1:0]    cfg_div_clamped;

    // Selector codes with no channel behind them read as "not pending", so
    // such requests are accepted and silently dropped.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_SPAN; gi++) begin : g_map
            if (gi < CHANNELS) begin : g_real
                assign pend_map[gi] = pend_flags[gi];
            end else begin : g_pad
                assign pend_map[gi] = 1'b0;
            end
        end
    endgenerate

    assign cfg_ready       = !pend_map[cfg_chan];
    assign cfg_div_clamped = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            localparam logic [SEL_W-1:0] CH_SEL = SEL_W'(gi);

            logic [WIDTH-1:0] cnt_reg, cnt_next;
            logic [WIDTH-1:0] div_reg, div_next;
            logic [WIDTH-1:0] high_reg, high_next;
            logic [WIDTH-1:0] pdiv_reg, pdiv_next;
            logic [WIDTH-1:0] phigh_reg, phigh_next;
            logic             pend_reg, pend_next;
            logic             clk_reg, clk_next;
            logic             tick_reg, tick_next;
            logic             wrap, apply, accept;

            // >= rather than == so a counter left beyond a shortened period
            // still wraps on the next edge.
            assign wrap   = cnt_reg >= (div_reg - WIDTH'(1));
            assign accept = cfg_valid && cfg_ready && (cfg_chan == CH_SEL);
            assign apply  = pend_reg && (wrap || !enable[gi]);

            always_comb begin
                cnt_next   = cnt_reg;
                div_next   = div_reg;
                high_next  = high_reg;
                pdiv_next  = pdiv_reg;
                phigh_next = phigh_reg;
                pend_next  = pend_reg;
                clk_next   = 1'b0;
                tick_next  = 1'b0;

                if (enable[gi]) begin
                    cnt_next  = wrap ? '0 : cnt_reg + WIDTH'(1);
                    clk_next  = cnt_reg < high_reg;
                    tick_next = wrap;
                end else begin
                    cnt_next  = '0;
                end

                // Pending settings swap in only once the old period is done
                // (or the channel is idle), so no runt or stretched pulse.
                if (apply) begin
                    div_next  = pdiv_reg;
                    high_next = phigh_reg;
                    cnt_next  = '0;
                    pend_next = 1'b0;
                end else if (accept) begin
                    pdiv_next  = cfg_div_clamped;
                    phigh_next = cfg_high;
                    pend_next  = 1'b1;
                end
            end

            always_ff @(posedge clock_in) begin
                if (reset) begin
                    cnt_reg   <= '0;
                    div_reg   <= DEFAULT_DIV;
                    high_reg  <= DEFAULT_HIGH;
                    pdiv_reg  <= DEFAULT_DIV;
                    phigh_reg <= DEFAULT_HIGH;
                    pend_reg  <= 1'b0;
                    clk_reg   <= 1'b0;
                    tick_reg  <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    div_reg   <= div_next;
                    high_reg  <= high_next;
                    pdiv_reg  <= pdiv_next;
                    phigh_reg <= phigh_next;
                    pend_reg  <= pend_next;
                    clk_reg   <= clk_next;
                    tick_reg  <= tick_next;
                end
            end

            assign pend_flags[gi] = pend_reg;
            assign clock_out[gi]  = clk_reg;
            assign tick[gi]       = tick_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (DEFAULT_DIV=10, 4 channels): waveforms are
// captured sample-by-sample on the falling edge and compared to hand-derived patterns.
module tb_clk_div_multi;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 28;
    localparam int SEL_W    = 2;

    logic                clock_in = 1'b0;
    logic                reset;
    logic [CHANNELS-1:0] enable;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [SEL_W-1:0]    cfg_chan;
    logic [WIDTH-1:0]    cfg_div;
    logic [WIDTH-1:0]    cfg_high;
    logic [CHANNELS-1:0] clock_out;
    logic [CHANNELS-1:0] tick;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_clk  [CHANNELS];
    logic [31:0] cap_tick [CHANNELS];
    logic [31:0] cap_rdy;

    always #5 clock_in = ~clock_in;

    clk_div_multi #(
        .CHANNELS    (CHANNELS),
        .WIDTH       (WIDTH),
        .SEL_W       (SEL_W),
        .DEFAULT_DIV (28'd10)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .clock_out (clock_out),
        .tick      (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift n falling-edge samples in; the earliest sample ends up most significant.
    task automatic capture(input int n);
        for (int c = 0; c < CHANNELS; c++) begin
            cap_clk[c]  = '0;
            cap_tick[c] = '0;
        end
        cap_rdy = '0;
        repeat (n) begin
            @(negedge clock_in);
            for (int c = 0; c < CHANNELS; c++) begin
                cap_clk[c]  = {cap_clk[c][30:0], clock_out[c]};
                cap_tick[c] = {cap_tick[c][30:0], tick[c]};
            end
            cap_rdy = {cap_rdy[30:0], cfg_ready};
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    // Presents one request for one clock edge; ready must be high when offered.
    task automatic send(input int ch, input int div, input int high);
        cfg_valid = 1'b1;
        cfg_chan  = SEL_W'(ch);
        cfg_div   = WIDTH'(div);
        cfg_high  = WIDTH'(high);
        $display("cfg ch%0d div=%0d high=%0d ready=%0b", ch, div, high, cfg_ready);
        check("cfg_ready_offer", 32'(cfg_ready), 32'd1);
        @(negedge clock_in);
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 4'hF;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_high  = '0;
        idle(3);

        // 1: reset state, then default 5 high / 5 low on every channel
        check("reset_clock_out", 32'(clock_out), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;
        capture(20);
        for (int c = 0; c < CHANNELS; c++) begin
            check($sformatf("t1_clk%0d", c), cap_clk[c], 32'(20'b11111000001111100000));
            check($sformatf("t1_tick%0d", c), cap_tick[c], 32'(20'b00000000010000000001));
        end

        // 2: ch1 reconfigured mid-period to div 4 / high 1
        idle(3);
        send(1, 4, 1);
        check("t2_ready_pending", 32'(cfg_ready), 32'd0);
        capture(17);
        check("t2_clk1", cap_clk[1], 32'(17'b10000010001000100));
        check("t2_tick1", cap_tick[1], 32'(17'b00000100010001000));
        check("t2_ready", cap_rdy, 32'(17'b00000111111111111));
        for (int c = 0; c < CHANNELS; c++) begin
            if (c != 1) begin
                check($sformatf("t2_clk%0d", c), cap_clk[c], 32'(17'b10000011111000001));
                check($sformatf("t2_tick%0d", c), cap_tick[c], 32'(17'b00000100000000010));
            end
        end

        // 3: ch2 div 0 clamps to 2
        send(2, 0, 1);
        capture(14);
        check("t3_clk2", cap_clk[2], 32'(14'b11100000101010));
        check("t3_tick2", cap_tick[2], 32'(14'b00000001010101));

        // 4: drop enable[3] while high, then restart a fresh period
        idle(6);
        check("t4_clk3_high", 32'(clock_out[3]), 32'd1);
        enable = 4'b0111;
        capture(3);
        check("t4_clk3_off", cap_clk[3], 32'h0);
        check("t4_tick3_off", cap_tick[3], 32'h0);
        enable = 4'hF;
        capture(11);
        check("t4_clk3_restart", cap_clk[3], 32'(11'b11111000001));
        check("t4_tick3_restart", cap_tick[3], 32'(11'b00000000010));

        // 5: ch0 high beyond the period (constant 1), then high 0 (constant 0)
        send(0, 10, 12);
        capture(15);
        check("t5_clk0_const1", cap_clk[0], 32'(15'b000111111111111));
        check("t5_tick0_const1", cap_tick[0], 32'(15'b001000000000100));
        send(0, 10, 0);
        capture(18);
        check("t5_clk0_const0", cap_clk[0], 32'(18'b111111100000000000));
        check("t5_tick0_const0", cap_tick[0], 32'(18'b000000100000000010));

        // 6: reset while ch1 has a pending config
        send(1, 6, 2);
        check("t6_ready_pending", 32'(cfg_ready), 32'd0);
        reset = 1'b1;
        @(negedge clock_in);
        check("t6_reset_clock_out", 32'(clock_out), 32'h0);
        check("t6_reset_tick", 32'(tick), 32'h0);
        check("t6_reset_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;
        capture(20);
        for (int c = 0; c < CHANNELS; c++) begin
            check($sformatf("t6_clk%0d", c), cap_clk[c], 32'(20'b11111000001111100000));
            check($sformatf("t6_tick%0d", c), cap_tick[c], 32'(20'b00000000010000000001));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
